// File: rtl/rotary_quadrature_generator_pkg.sv
// Shared state encodings, quadrature code constants and per-direction
// code tables for the rotary quadrature generator.
package rotary_quadrature_generator_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_Q1   = 3'd1,
      ST_Q2   = 3'd2,
      ST_Q3   = 3'd3,
      ST_Q4   = 3'd4
   } state_e;

   localparam logic [1:0] ROT_REST = 2'b00;
   localparam logic [1:0] ROT_A    = 2'b10;
   localparam logic [1:0] ROT_AB   = 2'b11;
   localparam logic [1:0] ROT_B    = 2'b01;

   // Index 0 is the first code of a detent, index 3 the settle code.
   localparam logic [3:0][1:0] RIGHT_SEQ = {ROT_REST, ROT_B, ROT_AB, ROT_A};
   localparam logic [3:0][1:0] LEFT_SEQ  = {ROT_REST, ROT_A, ROT_AB, ROT_B};

   function automatic logic [1:0] phase_code(input state_e st, input logic dir_left);
      logic [1:0] idx;
      idx = 2'(st - ST_Q1);
      if (st == ST_IDLE) return ROT_REST;
      return dir_left ? LEFT_SEQ[idx] : RIGHT_SEQ[idx];
   endfunction

endpackage

// File: rtl/rotary_pending_counter.sv
// Signed saturating backlog of step commands. Inputs that would overflow
// are discarded and flagged; the consume term is always applied.
module rotary_pending_counter #(
   parameter int WIDTH = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    inc,
   input  logic                    dec,
   input  logic                    consume,
   input  logic                    consume_left,
   output logic signed [WIDTH-1:0] pending,
   output logic                    dropped,
   output logic                    nonzero,
   output logic                    negative
);

   localparam logic signed [WIDTH:0] ONE = (WIDTH+1)'(1);
   localparam logic signed [WIDTH:0] MAX = (WIDTH+1)'((1 << (WIDTH-1)) - 1);

   logic signed [WIDTH-1:0] pending_q, pending_d;
   logic                    dropped_q, dropped_d;
   logic signed [WIDTH:0]   pend_x, contrib, with_in, base;

   always_comb begin
      pend_x  = {pending_q[WIDTH-1], pending_q};
      contrib = '0;
      if (inc && !dec)      contrib = ONE;
      else if (dec && !inc) contrib = -ONE;
      with_in   = pend_x + contrib;
      dropped_d = (with_in > MAX) || (with_in < -MAX);
      base      = dropped_d ? pend_x : with_in;
      // A started detent moves the backlog one step back toward zero.
      if (consume) base = base - (consume_left ? -ONE : ONE);
      pending_d = WIDTH'(base);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pending_q <= '0;
         dropped_q <= 1'b0;
      end else begin
         pending_q <= pending_d;
         dropped_q <= dropped_d;
      end
   end

   assign pending  = pending_q;
   assign dropped  = dropped_q;
   assign nonzero  = |pending_q;
   assign negative = pending_q[WIDTH-1];

endmodule

// File: rtl/rotary_quadrature_generator.sv
// Emits rotary-encoder A/B quadrature detents from queued step commands,
// one detent after another, each code held PHASE_CYCLES cycles.
module rotary_quadrature_generator
   import rotary_quadrature_generator_pkg::*;
#(
   parameter int PHASE_CYCLES  = 4,
   parameter int PENDING_WIDTH = 4
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            step_right,
   input  logic                            step_left,
   output logic [1:0]                      rotary,
   output logic                            busy,
   output logic                            done,
   output logic                            dropped,
   output logic signed [PENDING_WIDTH-1:0] pending
);

   localparam int TW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(PHASE_CYCLES - 1);

   state_e          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            dir_left_q, dir_left_d;
   logic [1:0]      rotary_q, rotary_d;
   logic            done_q, done_d;
   logic            start, pend_nz, pend_neg;

   rotary_pending_counter #(.WIDTH(PENDING_WIDTH)) u_pending (
      .clock        (clock),
      .reset        (reset),
      .inc          (step_right),
      .dec          (step_left),
      .consume      (start),
      .consume_left (pend_neg),
      .pending      (pending),
      .dropped      (dropped),
      .nonzero      (pend_nz),
      .negative     (pend_neg)
   );

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      dir_left_d = dir_left_q;
      start      = 1'b0;
      if (state_q == ST_IDLE) begin
         start = pend_nz;
      end else if (timer_q == TIMER_LAST) begin
         timer_d = '0;
         case (state_q)
            ST_Q1:   state_d = ST_Q2;
            ST_Q2:   state_d = ST_Q3;
            ST_Q3:   state_d = ST_Q4;
            default: begin
               state_d = ST_IDLE;
               start   = pend_nz;
            end
         endcase
      end else begin
         timer_d = timer_q + TW'(1);
      end
      // Back-to-back detents skip IDLE so the period stays 4*PHASE_CYCLES.
      if (start) begin
         state_d    = ST_Q1;
         timer_d    = '0;
         dir_left_d = pend_neg;
      end
      rotary_d = phase_code(state_d, dir_left_d);
      done_d   = (state_d == ST_Q4) && (timer_d == TIMER_LAST);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         timer_q    <= '0;
         dir_left_q <= 1'b0;
         rotary_q   <= ROT_REST;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         dir_left_q <= dir_left_d;
         rotary_q   <= rotary_d;
         done_q     <= done_d;
      end
   end

   assign rotary = rotary_q;
   assign done   = done_q;
   assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rotary_quadrature_generator.sv
// Bench for rotary_quadrature_generator: directed scenarios plus randomized
// stimulus against a detent-timeline reference model.
module tb_rotary_quadrature_generator;

   localparam int P   = 4;
   localparam int MAX = 7;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              step_right = 1'b0;
   logic              step_left = 1'b0;
   logic [1:0]        rotary;
   logic              busy, done, dropped;
   logic signed [3:0] pending;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Reference model: backlog as an integer, the detent as elapsed cycles
   int         m_pend = 0;
   bit         m_active = 0;
   bit         m_left = 0;
   int         m_el = 0;
   bit         m_done = 0;
   bit         m_drop = 0;
   logic [1:0] m_rot = 2'b00;
   logic [1:0] seq_r [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
   logic [1:0] seq_l [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

   rotary_quadrature_generator #(.PHASE_CYCLES(P), .PENDING_WIDTH(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .step_right (step_right),
      .step_left  (step_left),
      .rotary     (rotary),
      .busy       (busy),
      .done       (done),
      .dropped    (dropped),
      .pending    (pending)
   );

   always #5 clock = ~clock;

   task automatic model_edge(input bit r, input bit l, input bit rst);
      bit start;
      bit start_left;
      int nv;
      if (rst) begin
         m_pend = 0; m_active = 0; m_el = 0; m_drop = 0; m_done = 0; m_rot = 2'b00;
         return;
      end
      start = 0;
      start_left = (m_pend < 0);
      if (!m_active) start = (m_pend != 0);
      else if (m_el == 4*P-1) begin
         m_active = 0;
         start = (m_pend != 0);
      end else m_el++;
      nv = m_pend + int'(r && !l) - int'(l && !r);
      m_drop = (nv > MAX) || (nv < -MAX);
      if (!m_drop) m_pend = nv;
      if (start) begin
         m_left   = start_left;
         m_pend   = m_pend + (start_left ? 1 : -1);
         m_active = 1;
         m_el     = 0;
      end
      m_rot  = m_active ? (m_left ? seq_l[m_el / P] : seq_r[m_el / P]) : 2'b00;
      m_done = m_active && (m_el == 4*P-1);
   endtask

   task automatic run_cycle(input bit r, input bit l, input bit rst);
      @(negedge clock);
      step_right = r; step_left = l; reset = rst;
      @(posedge clock);
      cyc++;
      model_edge(r, l, rst);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || pending != 0) && n < 300) begin
         run_cycle(0, 0, 0);
         n++;
      end
      total++;
      if (busy || pending != 0) begin
         bad++;
         $display("FAIL idle_timeout busy=%0b pending=%0d required busy=0 pending=0", busy, pending);
      end
   endtask

   task automatic test_reset();
      run_cycle(0, 0, 1);
      run_cycle(0, 0, 1);
      total++;
      if ({rotary, busy, done, dropped, pending} !== 9'b0) begin
         bad++;
         $display("FAIL reset_state rotary=%b busy=%b done=%b dropped=%b pending=%0d required all 0",
                  rotary, busy, done, dropped, pending);
      end
   endtask

   task automatic test_single_right();
      logic [1:0] exp_rot;
      bit         exp_busy;
      while (cyc < 9) run_cycle(0, 0, 0);
      run_cycle(1, 0, 0);
      total++;
      if (pending !== 4'sd1 || rotary !== 2'b00) begin
         bad++;
         $display("FAIL single_cmd_edge pending=%0d rotary=%b required 1/00", pending, rotary);
      end
      while (cyc < 28) begin
         run_cycle(0, 0, 0);
         exp_rot  = (cyc <= 14) ? 2'b10 : (cyc <= 18) ? 2'b11 : (cyc <= 22) ? 2'b01 : 2'b00;
         exp_busy = (cyc <= 26);
         total++;
         if (rotary !== exp_rot || busy !== exp_busy || done !== (cyc == 26) || pending !== 4'sd0) begin
            bad++;
            $display("FAIL single_right edge=%0d rotary=%b busy=%b done=%b pending=%0d required %b/%b/%b/0",
                     cyc, rotary, busy, done, pending, exp_rot, exp_busy, cyc == 26);
         end
      end
   endtask

   task automatic test_left_x3();
      int dc[3];
      int nd = 0;
      int gaps = 0;
      int n = 0;
      for (int i = 0; i < 3; i++) run_cycle(0, 1, 0);
      while (nd < 3 && n < 120) begin
         run_cycle(0, 0, 0);
         n++;
         if (nd >= 1 && !busy) gaps++;
         if (done) begin dc[nd] = cyc; nd++; end
      end
      run_cycle(0, 0, 0);
      total++;
      if (nd != 3 || dc[1] - dc[0] != 16 || dc[2] - dc[1] != 16 || gaps != 0 || busy || pending != 0) begin
         bad++;
         $display("FAIL left_x3 dones=%0d spacing=%0d,%0d idle_gaps=%0d busy=%b pending=%0d required 3,16,16,0,0,0",
                  nd, dc[1] - dc[0], dc[2] - dc[1], gaps, busy, pending);
      end
   endtask

   task automatic test_saturate();
      int drops = 0;
      int dones = 0;
      int peak = 0;
      int n = 0;
      for (int i = 0; i < 9; i++) begin
         run_cycle(1, 0, 0);
         if (dropped) drops++;
         if (int'(pending) > peak) peak = int'(pending);
      end
      while ((busy || pending != 0) && n < 200) begin
         run_cycle(0, 0, 0);
         n++;
         if (dropped) drops++;
         if (done) dones++;
         if (rotary !== m_rot) begin
            total++; bad++;
            $display("FAIL saturate_rotary edge=%0d rotary=%b required %b", cyc, rotary, m_rot);
         end
      end
      total++;
      if (drops != 1 || dones != 8 || peak != MAX) begin
         bad++;
         $display("FAIL saturate drops=%0d detents=%0d peak=%0d required 1/8/7", drops, dones, peak);
      end
   endtask

   task automatic test_cancel();
      for (int i = 0; i < 5; i++) begin
         run_cycle(1, 1, 0);
         total++;
         if (pending !== 4'sd0 || rotary !== 2'b00 || dropped !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL cancel pending=%0d rotary=%b dropped=%b busy=%b required 0/00/0/0",
                     pending, rotary, dropped, busy);
         end
      end
   endtask

   task automatic test_reverse();
      int n = 0;
      int phase = 0;
      int zeros = 0;
      logic [1:0] nxt = 2'bxx;
      run_cycle(1, 0, 0);
      while (rotary !== 2'b11 && n < 20) begin run_cycle(0, 0, 0); n++; end
      run_cycle(0, 1, 0);
      for (int i = 0; i < 40; i++) begin
         run_cycle(0, 0, 0);
         case (phase)
            0: if (rotary == 2'b01) phase = 1;
            1: if (rotary == 2'b00) begin phase = 2; zeros = 1; end
            2: if (rotary == 2'b00) zeros++;
               else begin phase = 3; nxt = rotary; end
            default: ;
         endcase
      end
      total++;
      if (phase != 3 || zeros != 4 || nxt !== 2'b01) begin
         bad++;
         $display("FAIL reverse phase=%0d rest_cycles=%0d next_code=%b required 3/4/01", phase, zeros, nxt);
      end
      wait_idle();
   endtask

   task automatic test_reset_mid();
      int n = 0;
      int act = 0;
      for (int i = 0; i < 4; i++) run_cycle(1, 0, 0);
      while (rotary !== 2'b11 && n < 20) begin run_cycle(0, 0, 0); n++; end
      total++;
      if (rotary !== 2'b11 || pending !== 4'sd3) begin
         bad++;
         $display("FAIL reset_mid_setup rotary=%b pending=%0d required 11/3", rotary, pending);
      end
      run_cycle(0, 0, 1);
      total++;
      if (rotary !== 2'b00 || pending !== 4'sd0 || busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid rotary=%b pending=%0d busy=%b done=%b required 00/0/0/0",
                  rotary, pending, busy, done);
      end
      for (int i = 0; i < 20; i++) begin
         run_cycle(0, 0, 0);
         if (busy || done || rotary != 2'b00) act++;
      end
      total++;
      if (act != 0) begin
         bad++;
         $display("FAIL reset_mid_quiet active_cycles=%0d required 0", act);
      end
   endtask

   task automatic test_random();
      bit r, l, rst;
      for (int i = 0; i < 1500; i++) begin
         r   = ($urandom_range(0, 5) == 0);
         l   = ($urandom_range(0, 6) == 0);
         rst = ($urandom_range(0, 299) == 0);
         run_cycle(r, l, rst);
         total++;
         if ({rotary, busy, done, dropped, pending} !== {m_rot, m_active, m_done, m_drop, 4'(m_pend)}) begin
            bad++;
            $display("FAIL random edge=%0d rotary=%b busy=%b done=%b dropped=%b pending=%0d required %b/%b/%b/%b/%0d",
                     cyc, rotary, busy, done, dropped, pending, m_rot, m_active, m_done, m_drop, m_pend);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_right();
      wait_idle();
      test_left_x3();
      wait_idle();
      test_saturate();
      test_cancel();
      test_reverse();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
